// File: rtl/wbc_vic_pkg.sv
// Shared types and constants for the wbc_vic vectored interrupt controller.
package wbc_vic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } vic_state_e;

  localparam logic [15:0] VIC_VEC_MASK = 16'hFFFC;
  localparam int unsigned VIC_N_MAX    = 16;

  // Vectors are word aligned on the bus, so the two low bits never leave the block.
  function automatic logic [15:0] vic_mask_vec(input logic [15:0] v);
    return v & VIC_VEC_MASK;
  endfunction

endpackage

// File: rtl/wbc_vic_arb.sv
// Combinational request encoder for wbc_vic: lowest set index wins, or with VIC_RR_EN
// defined the search starts at rr_ptr_i and wraps from N-1 to 0.
module wbc_vic_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  ireq_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          valid_o,
  output logic [IW-1:0] win_o
);

  int unsigned   idx;
  logic [IW-1:0] sel;

  always_comb begin
    valid_o = 1'b0;
    win_o   = '0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
`ifdef VIC_RR_EN
      idx = (32'(rr_ptr_i) + k) % N;
`else
      idx = k;
`endif
      sel = IW'(idx);
      if (!valid_o && ireq_i[sel]) begin
        valid_o = 1'b1;
        win_o   = sel;
      end
    end
  end

`ifndef VIC_RR_EN
  logic unused_rr;
  assign unused_rr = ^rr_ptr_i;
`endif

endmodule

// File: rtl/wbc_vic.sv
// Vectored interrupt controller: arbitrates ireq, raises virq, answers istb with ivec/iack
// and pulses iack_dev for the serviced device. Define VIC_RR_EN for round-robin arbitration.
module wbc_vic
  import wbc_vic_pkg::*;
#(
  parameter int unsigned     N   = 4,
  parameter logic [N*16-1:0] VEC = {16'o0300, 16'o0100, 16'o0064, 16'o0060}
) (
  input  logic         clk_p,
  input  logic         rst_n,
  input  logic         vm_init,
  input  logic [N-1:0] ireq,
  output logic [N-1:0] iack_dev,
  output logic         virq,
  input  logic         istb,
  output logic         iack,
  output logic [15:0]  ivec
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  vic_state_e    state_q;
  logic [IW-1:0] winner_q;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] arb_win;
  logic          arb_valid;
  logic          virq_q;
  logic          iack_q;
  logic [15:0]   ivec_q;
  logic [N-1:0]  iack_dev_q;
  logic [15:0]   vec_tab [N];

  for (genvar g = 0; g < N; g++) begin : g_vec
    assign vec_tab[g] = VEC[16*g +: 16];
  end

  wbc_vic_arb #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .ireq_i   (ireq),
    .rr_ptr_i (rr_ptr),
    .valid_o  (arb_valid),
    .win_o    (arb_win)
  );

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      virq_q     <= 1'b0;
      iack_q     <= 1'b0;
      ivec_q     <= '0;
      iack_dev_q <= '0;
    end else if (vm_init) begin
      state_q    <= IDLE;
      winner_q   <= '0;
      virq_q     <= 1'b0;
      iack_q     <= 1'b0;
      ivec_q     <= '0;
      iack_dev_q <= '0;
    end else begin
      iack_dev_q <= '0;
      unique case (state_q)
        // Hold off arbitration during the acknowledge pulse so the device can drop its request.
        IDLE: begin
          if (iack_dev_q == '0 && arb_valid) begin
            winner_q <= arb_win;
            virq_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (istb) begin
            ivec_q  <= vic_mask_vec(vec_tab[winner_q]);
            iack_q  <= 1'b1;
            virq_q  <= 1'b0;
            state_q <= ACK;
          end else if (!ireq[winner_q]) begin
            virq_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        ACK: begin
          if (!istb) begin
            iack_q               <= 1'b0;
            ivec_q               <= '0;
            iack_dev_q[winner_q] <= 1'b1;
            state_q              <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef VIC_RR_EN
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] rr_ptr_d;

  assign rr_ptr_d = (winner_q == IW'(N - 1)) ? '0 : winner_q + 1'b1;

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (!vm_init && state_q == ACK && !istb) begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = '0;
`endif

  assign virq     = virq_q;
  assign iack     = iack_q;
  assign ivec     = ivec_q;
  assign iack_dev = iack_dev_q;

  a_n_range: assert property (@(posedge clk_p) (N >= 1) && (N <= VIC_N_MAX))
    else $error("wbc_vic: N out of range");

  a_istb_idle: assert property (@(posedge clk_p) disable iff (!rst_n || vm_init)
    !(state_q == IDLE && istb))
    else $error("wbc_vic: CPU raised istb with no interrupt pending");

endmodule

// File: tb/tb_wbc_vic.sv
// Directed bench for wbc_vic with a transaction-level reference model and per-cycle compare.
module tb_wbc_vic;

  localparam int unsigned N = 4;
  localparam logic [N*16-1:0] TB_VEC = {16'o0300, 16'o0100, 16'o0067, 16'o0060};

  logic         clk_p    = 1'b0;
  logic         rst_n    = 1'b0;
  logic         vm_init  = 1'b0;
  logic [N-1:0] ireq     = '0;
  logic         istb     = 1'b0;
  logic [N-1:0] iack_dev;
  logic         virq;
  logic         iack;
  logic [15:0]  ivec;

  int n_checks = 0;
  int n_errors = 0;
  bit auto_clear = 1'b1;

  always #5 clk_p = ~clk_p;

  wbc_vic #(
    .N   (N),
    .VEC (TB_VEC)
  ) dut (
    .clk_p    (clk_p),
    .rst_n    (rst_n),
    .vm_init  (vm_init),
    .ireq     (ireq),
    .iack_dev (iack_dev),
    .virq     (virq),
    .istb     (istb),
    .iack     (iack),
    .ivec     (ivec)
  );

  // Reference model: which device is being served, whether its vector was fetched,
  // and the pending acknowledge pulse.
  logic [15:0]  vec_tab [N] = '{16'o0060, 16'o0067, 16'o0100, 16'o0300};
  int           m_serv  = -1;
  bit           m_gnt   = 1'b0;
  logic [N-1:0] m_pulse = '0;
  int           m_rr    = 0;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      m_serv = -1; m_gnt = 1'b0; m_pulse = '0; m_rr = 0;
    end else if (vm_init) begin
      m_serv = -1; m_gnt = 1'b0; m_pulse = '0;
    end else if (m_serv < 0) begin
      if (m_pulse == '0 && ireq != '0) begin
        m_serv = pick(ireq, m_rr);
        m_gnt  = 1'b0;
      end
      m_pulse = '0;
    end else if (!m_gnt) begin
      if (istb) m_gnt = 1'b1;
      else if (!ireq[m_serv]) m_serv = -1;
    end else if (!istb) begin
      m_pulse         = '0;
      m_pulse[m_serv] = 1'b1;
`ifdef VIC_RR_EN
      m_rr = (m_serv + 1) % N;
`endif
      m_serv = -1;
      m_gnt  = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk_p) begin
    chk("cmp_virq", 16'(virq), 16'(m_serv >= 0 && !m_gnt));
    chk("cmp_iack", 16'(iack), 16'(m_gnt));
    chk("cmp_ivec", ivec, m_gnt ? (vec_tab[m_serv] & 16'hFFFC) : 16'h0000);
    chk("cmp_iack_dev", 16'(iack_dev), 16'(m_pulse));
  end

  // Devices drop their request when they see their acknowledge pulse (if auto_clear).
  task automatic tick();
    @(negedge clk_p);
    if (auto_clear) ireq = ireq & ~iack_dev;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic cpu_fetch(input int dly, input int hold,
                           output logic [15:0] v, output logic [N-1:0] dev);
    int t;
    t = 0;
    while (!virq && t < 50) begin
      tick();
      t++;
    end
    chk("virq_wait", 16'(virq), 16'd1);
    repeat (dly) tick();
    istb = 1'b1;
    tick();
    chk("iack_latency", 16'(iack), 16'd1);
    v = ivec;
    repeat (hold) tick();
    istb = 1'b0;
    tick();
    chk("iack_drop", 16'(iack), 16'd0);
    dev = iack_dev;
  endtask

  logic [15:0]  v1, v2;
  logic [N-1:0] d1, d2;
  logic [N-1:0] exp_order [4];

  initial begin
`ifdef VIC_RR_EN
    exp_order = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
`else
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    tick();
    tick();
    chk("rst_virq", 16'(virq), 16'd0);
    chk("rst_iack", 16'(iack), 16'd0);
    chk("rst_ivec", ivec, 16'd0);
    chk("rst_iack_dev", 16'(iack_dev), 16'd0);
    #2 rst_n = 1'b1;
    tick();

    // Single request, masked vector (table entry 0067 -> 0064).
    ireq = 4'b0010;
    tick();
    chk("t1_virq_1cyc", 16'(virq), 16'd1);
    cpu_fetch(3, 2, v1, d1);
    chk("t1_ivec", v1, 16'o0064);
    chk("t1_dev", 16'(d1), 16'b0010);
    tick();
    chk("t1_dev_one_cycle", 16'(iack_dev), 16'd0);

    // Simultaneous requests 1 and 3.
    do_reset();
    ireq = 4'b1010;
    cpu_fetch(1, 1, v1, d1);
    cpu_fetch(2, 3, v2, d2);
    chk("t2_first_ivec", v1, 16'o0064);
    chk("t2_first_dev", 16'(d1), 16'b0010);
    chk("t2_second_ivec", v2, 16'o0300);
    chk("t2_second_dev", 16'(d2), 16'b1000);

    // Passive release before istb.
    tick();
    ireq = 4'b0100;
    tick();
    chk("t3_virq_up", 16'(virq), 16'd1);
    tick();
    ireq = 4'b0000;
    tick();
    chk("t3_virq_down", 16'(virq), 16'd0);
    chk("t3_no_dev", 16'(iack_dev), 16'd0);
    tick();
    chk("t3_no_dev_later", 16'(iack_dev), 16'd0);

    // Bus init during the vector acknowledge.
    ireq = 4'b0001;
    for (int t = 0; t < 50 && !virq; t++) tick();
    istb = 1'b1;
    tick();
    chk("t4_iack_up", 16'(iack), 16'd1);
    vm_init = 1'b1;
    istb    = 1'b0;
    tick();
    chk("t4_init_iack", 16'(iack), 16'd0);
    chk("t4_init_ivec", ivec, 16'd0);
    chk("t4_init_virq", 16'(virq), 16'd0);
    chk("t4_init_dev", 16'(iack_dev), 16'd0);
    vm_init = 1'b0;
    cpu_fetch(1, 1, v1, d1);
    chk("t4_fresh_ivec", v1, 16'o0060);
    chk("t4_fresh_dev", 16'(d1), 16'b0001);

    // Requests 0 and 1 held high across four rounds.
    do_reset();
    auto_clear = 1'b0;
    ireq = 4'b0011;
    for (int r = 0; r < 4; r++) begin
      cpu_fetch(1, 1, v1, d1);
      chk($sformatf("t5_round%0d_dev", r), 16'(d1), 16'(exp_order[r]));
    end
    ireq = 4'b0000;
    repeat (3) tick();
    auto_clear = 1'b1;

    // Asynchronous reset while a request is pending at the CPU.
    do_reset();
    ireq = 4'b0100;
    tick();
    chk("t6_virq_up", 16'(virq), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_virq", 16'(virq), 16'd0);
    chk("t6_async_iack", 16'(iack), 16'd0);
    chk("t6_async_ivec", ivec, 16'd0);
    chk("t6_async_dev", 16'(iack_dev), 16'd0);
    ireq = 4'b0000;
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("t6_no_dev", 16'(iack_dev), 16'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
